// File: rtl/l1pa_regfile_loader_if.sv
// Bus bundle between the L1PA regfile loader and its host/config side.
// The loader uses the slave modport; a host model or bench uses master.
//
// Handshake: a config beat transfers on a rising clock edge where
// cfg_valid and cfg_ready are both high. The host holds cfg_shift,
// cfg_delta, cfg_isGtr and cfg_last stable while cfg_valid is high and
// may drop cfg_valid at any time; cfg_ready never depends on cfg_valid.
interface l1pa_regfile_loader_if #(
   parameter int ADDR_WIDTH  = 5,
   parameter int PAGE_WIDTH  = 7,
   parameter int SHIFT_WIDTH = 3,
   parameter int DELTA_WIDTH = 3
);
   // session control
   logic                   start;
   logic [ADDR_WIDTH-1:0]  start_addr;
   // config beat stream
   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [SHIFT_WIDTH-1:0] cfg_shift;
   logic [DELTA_WIDTH-1:0] cfg_delta;
   logic                   cfg_isGtr;
   logic                   cfg_last;
   // register file write / readback port
   logic                   regfile_we;
   logic [ADDR_WIDTH-1:0]  regfile_waddr;
   logic [PAGE_WIDTH-1:0]  regfile_wdata;
   logic [ADDR_WIDTH-1:0]  regfile_rd_addr;
   logic [PAGE_WIDTH-1:0]  regfile_rd_data;
   // status
   logic                   rd_lock;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic [1:0]             err_code;
   logic [ADDR_WIDTH:0]    page_cnt;

   modport master (
      output start, start_addr,
      output cfg_valid, cfg_shift, cfg_delta, cfg_isGtr, cfg_last,
      output regfile_rd_data,
      input  cfg_ready,
      input  regfile_we, regfile_waddr, regfile_wdata, regfile_rd_addr,
      input  rd_lock, busy, done, err, err_code, page_cnt
   );

   modport slave (
      input  start, start_addr,
      input  cfg_valid, cfg_shift, cfg_delta, cfg_isGtr, cfg_last,
      input  regfile_rd_data,
      output cfg_ready,
      output regfile_we, regfile_waddr, regfile_wdata, regfile_rd_addr,
      output rd_lock, busy, done, err, err_code, page_cnt
   );
endinterface

// File: rtl/l1pa_regfile_loader.sv
// L1PA control register file loader (REGFILE_SOL4 page layout).
// Takes L1PA shift-pattern beats from the config bus, range-checks them
// against the share-group size, packs each into a type-0 page
// {shift, delta, isGtr} and writes the pages to consecutive regfile
// addresses while rd_lock keeps the SCU reader off the file.
//
// Optional build macro L1PA_LOADER_VERIFY_EN: after the last write the
// loader reads every written page back and compares it with a shadow
// copy before signalling done. The regfile read port is expected to
// return write-first data when the read address equals the address being
// written in the same cycle (only matters for one-page sessions).
//
// dbg_state exposes the FSM encoding: 0 IDLE, 1 LOAD, 2 VERIFY, 3 ERR.
module l1pa_regfile_loader #(
   parameter int PAGE_NUM    = 32,
   parameter int PAGE_WIDTH  = 7,
   parameter int ADDR_WIDTH  = 5,
   parameter int SHIFT_WIDTH = 3,
   parameter int DELTA_WIDTH = 3,
   parameter int GROUP_SIZE  = 5
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   l1pa_regfile_loader_if.slave bus,
   output logic [1:0]           dbg_state
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PAGE_NUM - 1);

`ifdef L1PA_LOADER_VERIFY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_VERIFY = 2'd2,
      S_ERR    = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ERR  = 2'd3
   } state_t;
`endif

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  ptr;
   logic                   cfg_ready_q;
   logic                   we_q;
   logic [ADDR_WIDTH-1:0]  waddr_q;
   logic [PAGE_WIDTH-1:0]  wdata_q;
   logic                   rd_lock_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
   logic [1:0]             err_code_q;
   logic [ADDR_WIDTH:0]    page_cnt_q;

   logic                   beat_fire;
   logic                   drc_bad;
   logic                   at_top;
   logic [PAGE_WIDTH-1:0]  beat_page;

   // cfg_ready is only ever high in LOAD, so a fire is always a LOAD beat
   assign beat_fire = bus.cfg_valid && cfg_ready_q;
   // a pattern or delta outside the share group cannot be programmed
   assign drc_bad   = (32'(bus.cfg_shift) >= 32'(GROUP_SIZE)) ||
                      (32'(bus.cfg_delta) >= 32'(GROUP_SIZE));
   // last page of the file; a non-final beat here has nowhere to go next
   assign at_top    = (ptr == LAST_ADDR);
   assign beat_page = {bus.cfg_shift, bus.cfg_delta, bus.cfg_isGtr};

`ifdef L1PA_LOADER_VERIFY_EN
   logic [PAGE_WIDTH-1:0]  shadow [PAGE_NUM];
   logic [ADDR_WIDTH-1:0]  base_addr;
   logic [ADDR_WIDTH-1:0]  rd_addr_q;
   logic [ADDR_WIDTH-1:0]  cmp_addr;
   logic                   cmp_valid;
   logic [ADDR_WIDTH:0]    iss_left;
   logic                   cmp_bad;

   // readback page in this cycle belongs to the address issued last cycle
   assign cmp_bad = (bus.regfile_rd_data != shadow[cmp_addr]);

   // shadow copy of every page written in this session, indexed by address
   always_ff @(posedge sys_clk) begin
      if (state == S_LOAD && beat_fire && !drc_bad) begin
         shadow[ptr] <= beat_page;
      end
   end
`endif

   // main control FSM; all bus outputs are registered here
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         cfg_ready_q <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         rd_lock_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'd0;
         page_cnt_q  <= '0;
`ifdef L1PA_LOADER_VERIFY_EN
         base_addr   <= '0;
         rd_addr_q   <= '0;
         cmp_addr    <= '0;
         cmp_valid   <= 1'b0;
         iss_left    <= '0;
`endif
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state)
            S_IDLE, S_ERR: begin
               if (bus.start) begin
                  state       <= S_LOAD;
                  ptr         <= bus.start_addr;
                  page_cnt_q  <= '0;
                  err_q       <= 1'b0;
                  err_code_q  <= 2'd0;
                  busy_q      <= 1'b1;
                  rd_lock_q   <= 1'b1;
                  cfg_ready_q <= 1'b1;
`ifdef L1PA_LOADER_VERIFY_EN
                  base_addr   <= bus.start_addr;
`endif
               end else if (state == S_IDLE) begin
                  // release the reader one cycle after a successful done
                  busy_q    <= 1'b0;
                  rd_lock_q <= 1'b0;
               end
            end

            S_LOAD: begin
               if (beat_fire) begin
                  if (drc_bad) begin
                     // illegal beat: drop it, regfile contents stay locked
                     state       <= S_ERR;
                     err_q       <= 1'b1;
                     err_code_q  <= 2'd1;
                     cfg_ready_q <= 1'b0;
                     busy_q      <= 1'b0;
                  end else begin
                     we_q       <= 1'b1;
                     waddr_q    <= ptr;
                     wdata_q    <= beat_page;
                     page_cnt_q <= page_cnt_q + 1'b1;
                     if (bus.cfg_last) begin
                        cfg_ready_q <= 1'b0;
`ifdef L1PA_LOADER_VERIFY_EN
                        // first read address goes out with the last write
                        state     <= S_VERIFY;
                        rd_addr_q <= base_addr;
                        iss_left  <= page_cnt_q + 1'b1;
                        cmp_valid <= 1'b0;
`else
                        state  <= S_IDLE;
                        done_q <= 1'b1;
`endif
                     end else if (at_top) begin
                        // file full but more beats pending; never wrap
                        state       <= S_ERR;
                        err_q       <= 1'b1;
                        err_code_q  <= 2'd2;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                     end else begin
                        ptr <= ptr + 1'b1;
                     end
                  end
               end
            end

`ifdef L1PA_LOADER_VERIFY_EN
            S_VERIFY: begin
               // issue side: one read address per cycle, hold the last one
               if (iss_left != '0) begin
                  cmp_valid <= 1'b1;
                  cmp_addr  <= rd_addr_q;
                  iss_left  <= iss_left - 1'b1;
                  if (iss_left != (ADDR_WIDTH+1)'(1)) begin
                     rd_addr_q <= rd_addr_q + 1'b1;
                  end
               end else begin
                  cmp_valid <= 1'b0;
               end
               // compare side: data returned for the previous address
               if (cmp_valid) begin
                  if (cmp_bad) begin
                     state      <= S_ERR;
                     err_q      <= 1'b1;
                     err_code_q <= 2'd3;
                     busy_q     <= 1'b0;
                     cmp_valid  <= 1'b0;
                  end else if (iss_left == '0) begin
                     state     <= S_IDLE;
                     done_q    <= 1'b1;
                     cmp_valid <= 1'b0;
                  end
               end
            end
`endif

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_ready     = cfg_ready_q;
   assign bus.regfile_we    = we_q;
   assign bus.regfile_waddr = waddr_q;
   assign bus.regfile_wdata = wdata_q;
   assign bus.rd_lock       = rd_lock_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.err_code      = err_code_q;
   assign bus.page_cnt      = page_cnt_q;
   assign dbg_state         = state;

`ifdef L1PA_LOADER_VERIFY_EN
   assign bus.regfile_rd_addr = rd_addr_q;
`else
   // no readback path in this build
   logic unused_rd_data;
   assign bus.regfile_rd_addr = '0;
   assign unused_rd_data      = ^bus.regfile_rd_data;
`endif

endmodule

// File: doc/l1pa_regfile_loader.md
Name: l1pa_regfile_loader

Overview:
- Write-side counterpart of the L1PA control register file (memShare_regFile, REGFILE_SOL4 layout).
- Accepts a stream of L1PA shift-pattern configuration beats from the host/config bus over a valid/ready handshake.
- Checks each beat against the share-group design rules and packs it into a type-0 page {pattern, shift delta, isGtr}.
- Writes the pages sequentially into the register file while holding off the SCU reader through a lock flag.

Parameters:
PAGE_NUM, 32, number of regfile pages
PAGE_WIDTH, 7, page width = SHIFT_WIDTH+DELTA_WIDTH+1
ADDR_WIDTH, 5, regfile address width
SHIFT_WIDTH, 3, L1PA pattern field width
DELTA_WIDTH, 3, L1PA shift delta field width
GROUP_SIZE, 5, requestors per share group (legal pattern/delta range 0..GROUP_SIZE-1)

Ports:
sys_clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begin a load session (honoured only in IDLE or ERR)
start_addr  in  ADDR_WIDTH  first page written
cfg_valid  in  1  config beat valid
cfg_ready  out  1  loader can accept beat
cfg_shift  in  SHIFT_WIDTH  L1PA pattern
cfg_delta  in  DELTA_WIDTH  L1PA shift delta
cfg_isGtr  in  1  isGtr / sequence pointer bit
cfg_last  in  1  final beat of session
regfile_we  out  1  page write strobe
regfile_waddr  out  ADDR_WIDTH  page write address
regfile_wdata  out  PAGE_WIDTH  {shift, delta, isGtr}, isGtr at bit 0
regfile_rd_addr  out  ADDR_WIDTH  readback address (verify option only)
regfile_rd_data  in  PAGE_WIDTH  readback data, 1-cycle latency
rd_lock  out  1  SCU must not read regfile while high
busy  out  1  session in progress
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error flag
err_code  out  2  0 none, 1 DRC range, 2 address overflow, 3 readback mismatch
page_cnt  out  ADDR_WIDTH+1  pages written in current/last session

Behaviour:
- Reset: all outputs 0, including cfg_ready, regfile_*, rd_lock, busy, done, err, err_code, page_cnt. State IDLE.
- States: IDLE, LOAD, VERIFY (option only), ERR.
- IDLE --start--> LOAD:
  - Write pointer <= start_addr; page_cnt <= 0; err/err_code cleared.
  - busy=1 and rd_lock=1 from the cycle after start.
- LOAD:
  - cfg_ready=1. A beat is accepted when cfg_valid && cfg_ready.
  - Accepted beat: registered write 1 cycle later (regfile_we=1 for exactly 1 cycle, waddr=pointer, wdata={cfg_shift,cfg_delta,cfg_isGtr}).
  - After the write, pointer increments and page_cnt increments.
  - Back-to-back beats sustain one write per cycle.
- DRC: cfg_shift>=GROUP_SIZE or cfg_delta>=GROUP_SIZE.
  - That beat is not written.
  - Next cycle: err=1, err_code=1, state ERR.
- Overflow: a legal beat accepted at pointer PAGE_NUM-1 with cfg_last=0.
  - Its write is performed.
  - Then state ERR with err_code=2. No address wrap.
- A legal beat with cfg_last=1 at pointer PAGE_NUM-1 completes normally.
- Last beat (legal) without the option:
  - Write cycle coincides with done=1.
  - busy and rd_lock drop the following cycle; state returns to IDLE.
- ERR:
  - cfg_ready=0, rd_lock=1 (regfile contents untrusted), busy=0.
  - err and err_code held until a new start, which re-enters LOAD.
- start in LOAD/VERIFY is ignored.
- cfg_valid in IDLE/ERR is ignored (ready=0).
- page_cnt holds its value after a session ends.
- Reset mid-session: immediate return to all-zero outputs. Partially written pages are not cleared.

Optional Feature:
Macro L1PA_LOADER_VERIFY_EN.
- Defined: after the last write, enter VERIFY. cfg_ready=0; rd_lock stays 1.
  - regfile_rd_addr steps start_addr..last address, one per cycle.
  - Each returned page (1 cycle later) is compared with a shadow copy held in loader registers.
  - First mismatch: ERR, err_code=3.
  - All match: done pulse one cycle after the final compare, then IDLE.
  - Added latency is page_cnt+1 cycles.
- Undefined: no VERIFY state, regfile_rd_addr tied 0, regfile_rd_data unused, no shadow storage.

Test Plan:
- Reset asserted mid-LOAD after 3 writes -> all outputs 0 in the same cycle; next start restarts from start_addr.
- start_addr=0, 4 back-to-back legal beats (shift=2,delta=1,isGtr=1 ...), last on 4th -> writes at addr 0..3 on consecutive cycles, wdata=7'b0100011 for first beat, done pulse, page_cnt=4, rd_lock low afterwards.
- Beat with cfg_shift=5 as 2nd beat -> only addr 0 written, err=1, err_code=1, cfg_ready=0; new start clears err.
- start_addr=30, 3 legal beats, none last -> writes at 30 and 31, then err_code=2 and third beat never accepted.
- cfg_valid toggling every other cycle with start pulsed during LOAD -> writes only on accepted beats, start ignored, addresses contiguous.
- With L1PA_LOADER_VERIFY_EN, regfile model corrupts page 2 of a 4-page load -> err_code=3, no done; uncorrupted run -> done 5 cycles after last write.
